// File: rtl/comp_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : comp_seq_ctrl
// Brief    : Nibble-serial unsigned comparator sequencer. Reuses one 4-bit
//            compare slice, walking MSB nibble to LSB nibble and stopping at
//            the first mismatch. Result is offered on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module comp_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] c_IDX_TOP = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;

  logic [WIDTH-1:0]  w_sh_a;
  logic [WIDTH-1:0]  w_sh_b;
  logic [3:0]        w_nib_a;
  logic [3:0]        w_nib_b;

  // Bring the nibble under inspection down to bit 0 of each operand copy
  always_comb begin
    w_sh_a  = r_a >> {r_idx, 2'b00};
    w_sh_b  = r_b >> {r_idx, 2'b00};
    w_nib_a = w_sh_a[3:0];
    w_nib_b = w_sh_b[3:0];
  end

  // Accept is only possible while idle; this reads 1 throughout reset
  assign in_ready = (r_state == S_IDLE);

  // Sequencer: latch operands, step nibbles MSB-first, hold result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= c_IDX_TOP;
      r_a       <= '0;
      r_b       <= '0;
      out_valid <= 1'b0;
      a_eq_b    <= 1'b0;
      a_gt_b    <= 1'b0;
      a_lt_b    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= c_IDX_TOP;
            a_eq_b  <= 1'b0;
            a_gt_b  <= 1'b0;
            a_lt_b  <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          if (w_nib_a != w_nib_b) begin
            // First differing nibble from the top decides the ordering
            a_gt_b    <= (w_nib_a > w_nib_b);
            a_lt_b    <= (w_nib_a < w_nib_b);
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_idx == '0) begin
            a_eq_b    <= 1'b1;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            a_eq_b    <= 1'b0;
            a_gt_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_comp_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_comp_seq_ctrl
// Brief    : Directed self-checking bench for comp_seq_ctrl (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_comp_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        a_eq_b;
  logic        a_gt_b;
  logic        a_lt_b;
  logic        busy;

  int num_checks;
  int num_errors;

  comp_seq_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_eq_b    (a_eq_b),
    .a_gt_b    (a_gt_b),
    .a_lt_b    (a_lt_b),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for exactly one accept edge
  task automatic start_op(input logic [15:0] va, input logic [15:0] vb);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = ~va;
    b        = vb ^ 16'h5A5A;
  endtask

  // Count edges until out_valid; -1 if it never rises within the budget
  task automatic wait_result(output int k);
    k = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 16'h1111;
    b         = 16'h2222;
    out_ready = 1'b0;
    #2;
    num_checks++;
    if ({in_ready, out_valid, busy, a_eq_b, a_gt_b, a_lt_b} !== 6'b100000) begin
      num_errors++;
      $display("FAIL reset_state: got %b expected %b",
               {in_ready, out_valid, busy, a_eq_b, a_gt_b, a_lt_b}, 6'b100000);
    end
    tick();
    tick();
    num_checks++;
    if ({in_ready, busy} !== 2'b10) begin
      num_errors++;
      $display("FAIL reset_ignores_in_valid: got %b expected %b", {in_ready, busy}, 2'b10);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    num_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      num_errors++;
      $display("FAIL post_reset_idle: got %b expected %b", {in_ready, out_valid, busy}, 3'b100);
    end
  endtask

  task automatic test_equal();
    int k;
    start_op(16'h1234, 16'h1234);
    num_checks++;
    if ({in_ready, busy, out_valid} !== 3'b010) begin
      num_errors++;
      $display("FAIL eq_accept: got %b expected %b", {in_ready, busy, out_valid}, 3'b010);
    end
    wait_result(k);
    num_checks++;
    if (k !== 4) begin
      num_errors++;
      $display("FAIL eq_latency: got %0d expected %0d", k, 4);
    end
    num_checks++;
    if ({a_eq_b, a_gt_b, a_lt_b, in_ready} !== 4'b1000) begin
      num_errors++;
      $display("FAIL eq_flags: got %b expected %b", {a_eq_b, a_gt_b, a_lt_b, in_ready}, 4'b1000);
    end
    take_result();
    num_checks++;
    if ({in_ready, out_valid, busy, a_eq_b, a_gt_b, a_lt_b} !== 6'b100000) begin
      num_errors++;
      $display("FAIL eq_release: got %b expected %b",
               {in_ready, out_valid, busy, a_eq_b, a_gt_b, a_lt_b}, 6'b100000);
    end
  endtask

  task automatic test_early_exit_backpressure();
    int k;
    start_op(16'hA000, 16'h5FFF);
    wait_result(k);
    num_checks++;
    if (k !== 1) begin
      num_errors++;
      $display("FAIL gt_latency: got %0d expected %0d", k, 1);
    end
    num_checks++;
    if ({a_eq_b, a_gt_b, a_lt_b} !== 3'b010) begin
      num_errors++;
      $display("FAIL gt_flags: got %b expected %b", {a_eq_b, a_gt_b, a_lt_b}, 3'b010);
    end
    // Hold off the consumer; a stray in_valid pulse must not be taken
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a        = 16'h0001;
        b        = 16'h0009;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      num_checks++;
      if ({out_valid, a_eq_b, a_gt_b, a_lt_b, in_ready, busy} !== 6'b101001) begin
        num_errors++;
        $display("FAIL backpressure_hold[%0d]: got %b expected %b", i,
                 {out_valid, a_eq_b, a_gt_b, a_lt_b, in_ready, busy}, 6'b101001);
      end
    end
    in_valid = 1'b0;
    take_result();
    num_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      num_errors++;
      $display("FAIL backpressure_release: got %b expected %b", {in_ready, out_valid, busy}, 3'b100);
    end
    // Next pair is accepted on the very next edge
    start_op(16'h0001, 16'h0002);
    num_checks++;
    if ({in_ready, busy} !== 2'b01) begin
      num_errors++;
      $display("FAIL next_accept: got %b expected %b", {in_ready, busy}, 2'b01);
    end
    wait_result(k);
    num_checks++;
    if (k !== 4 || {a_eq_b, a_gt_b, a_lt_b} !== 3'b001) begin
      num_errors++;
      $display("FAIL next_result: got k=%0d flags=%b expected k=4 flags=001", k,
               {a_eq_b, a_gt_b, a_lt_b});
    end
    take_result();
  endtask

  task automatic test_lsb_mismatch();
    int k;
    start_op(16'h1230, 16'h1231);
    wait_result(k);
    num_checks++;
    if (k !== 4) begin
      num_errors++;
      $display("FAIL lt_latency: got %0d expected %0d", k, 4);
    end
    num_checks++;
    if ({a_eq_b, a_gt_b, a_lt_b} !== 3'b001) begin
      num_errors++;
      $display("FAIL lt_flags: got %b expected %b", {a_eq_b, a_gt_b, a_lt_b}, 3'b001);
    end
    take_result();
  endtask

  task automatic test_reset_mid_op();
    int k;
    start_op(16'h0000, 16'h0000);
    tick();
    // Now inside the second compare cycle
    rst = 1'b1;
    #1;
    num_checks++;
    if ({in_ready, out_valid, busy, a_eq_b, a_gt_b, a_lt_b} !== 6'b100000) begin
      num_errors++;
      $display("FAIL abort_immediate: got %b expected %b",
               {in_ready, out_valid, busy, a_eq_b, a_gt_b, a_lt_b}, 6'b100000);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      num_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
        num_errors++;
        $display("FAIL abort_no_pulse[%0d]: got %b expected %b", i,
                 {in_ready, out_valid, busy}, 3'b100);
      end
    end
    start_op(16'hFFFF, 16'hFFFE);
    wait_result(k);
    num_checks++;
    if (k !== 4 || {a_eq_b, a_gt_b, a_lt_b} !== 3'b010) begin
      num_errors++;
      $display("FAIL after_abort: got k=%0d flags=%b expected k=4 flags=010", k,
               {a_eq_b, a_gt_b, a_lt_b});
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    int k;
    out_ready = 1'b1;
    start_op(16'h0000, 16'h0000);
    wait_result(k);
    num_checks++;
    if (k !== 4 || {a_eq_b, a_gt_b, a_lt_b} !== 3'b100) begin
      num_errors++;
      $display("FAIL b2b_first: got k=%0d flags=%b expected k=4 flags=100", k,
               {a_eq_b, a_gt_b, a_lt_b});
    end
    // Offer the second pair while the first result is being taken
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    in_valid = 1'b1;
    tick();
    num_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      num_errors++;
      $display("FAIL b2b_idle_gap: got %b expected %b", {in_ready, out_valid, busy}, 3'b100);
    end
    tick();
    in_valid = 1'b0;
    num_checks++;
    if ({in_ready, busy} !== 2'b01) begin
      num_errors++;
      $display("FAIL b2b_second_accept: got %b expected %b", {in_ready, busy}, 2'b01);
    end
    wait_result(k);
    num_checks++;
    if (k !== 4 || {a_eq_b, a_gt_b, a_lt_b} !== 3'b100) begin
      num_errors++;
      $display("FAIL b2b_second: got k=%0d flags=%b expected k=4 flags=100", k,
               {a_eq_b, a_gt_b, a_lt_b});
    end
    tick();
    out_ready = 1'b0;
    num_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      num_errors++;
      $display("FAIL b2b_end: got %b expected %b", {in_ready, out_valid}, 2'b10);
    end
  endtask

  initial begin
    num_checks = 0;
    num_errors = 0;
    test_reset();
    test_equal();
    test_early_exit_backpressure();
    test_lsb_mismatch();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
`default_nettype wire
